minimac3_rx: RTL and testbench
==============================

Name: minimac3_rx

Overview:
- Parametrised next-generation Ethernet receive engine in the phy_rx_clk domain.
- Assembles PHY symbols (MII nibbles or GMII bytes) into bytes and writes them into one of NSLOTS host-released receive buffers.
- Hands each completed frame back with its length and status.
- Adds frame dropping when no slot is free, truncation at buffer end, PHY error capture, and drop statistics.

Parameters:
- NSLOTS, 2, number of receive buffer slots (1..8).
- SLOT_AW, 11, byte-address width of each slot; slot size is 2^SLOT_AW bytes.
- PHY_W, 4, PHY data width: 4 = MII (two symbols per byte, low nibble first), 8 = GMII (one symbol per byte).

Ports:
- phy_rx_clk  in  1  sole clock.
- phy_rx_rst_n  in  1  synchronous active-low reset.
- rx_ready  in  NSLOTS  one-cycle pulse per slot; host releases that slot for reception.
- rx_done  out  NSLOTS  one-cycle pulse; the frame in that slot is complete.
- rx_err  out  NSLOTS  valid with rx_done; frame had phy_rx_er, was truncated, or (if enabled) failed CRC.
- rx_count  out  NSLOTS*SLOT_AW  per-slot byte count, slot i at bits [i*SLOT_AW +: SLOT_AW]; stable from rx_done until the next frame starts in that slot.
- rxb_dat  out  8  write data shared by all slots.
- rxb_adr  out  SLOT_AW  write address, equal to the active slot's count.
- rxb_we  out  NSLOTS  one-hot write enable for the active slot.
- drop_count  out  16  saturating count of frames dropped for lack of a free slot.
- phy_dv  in  1  PHY data valid.
- phy_rx_data  in  PHY_W  PHY data.
- phy_rx_er  in  1  PHY receive error.

Behaviour:
- Reset: all outputs 0; available-slot mask 0; state IDLE; drop_count 0. Reset mid-frame abandons the frame with no rx_done.
- Available mask: avail <= (avail | rx_ready) & ~rx_done every cycle. rx_ready on the same slot as rx_done in the same cycle leaves that slot unavailable (done wins).
- Slot choice: in IDLE, the active slot is the lowest-index set bit of avail, re-evaluated every IDLE cycle and frozen when phy_dv first rises.
- States:
  - IDLE: on phy_dv with a free slot, clear that slot's count and capture the first symbol. Go to LOAD_HI when PHY_W=4, or LOAD_LO when PHY_W=8. On phy_dv with no free slot, go to DROP.
  - LOAD_HI (MII only): on phy_dv, capture the high nibble and go to LOAD_LO. If phy_dv is low, go to TERMINATE; an odd trailing nibble is discarded.
  - LOAD_LO: write the assembled byte (rxb_we one-hot, rxb_adr = count) and increment count. If phy_dv is high, capture the next symbol and return to LOAD_HI (MII) or stay (GMII). If phy_dv is low, go to TERMINATE.
  - TERMINATE: pulse rx_done and rx_err for the active slot, then go to IDLE.
  - DROP: wait for phy_dv low, saturating-increment drop_count, go to IDLE. No writes and no rx_done.
- Latency: a byte is written one cycle after its last symbol; rx_done asserts one cycle after phy_dv falls.
- Truncation: when count = 2^SLOT_AW - 1, further writes are suppressed and count holds. The error flag sets; the frame continues to the end of phy_dv.
- phy_rx_er sampled high while phy_dv is high in any LOAD state sets the error flag. The flag clears on frame start.
- drop_count holds at 16'hFFFF.

Optional Feature:
- MINIMAC3_RX_CRC_EN defined: an in-line CRC-32 (IEEE 802.3, reflected, init 0xFFFFFFFF) runs over every written byte. If the residue is not 0xC704DD7B at TERMINATE, the error flag sets.
- Not defined: no CRC logic; rx_err reflects only PHY error and truncation.

Decomposition:
- Package minimac3_pkg holds:
  - state encoding IDLE/LOAD_LO/LOAD_HI/TERMINATE/DROP;
  - CRC polynomial and residue constants;
  - PHY_W legal values.
- One sub-module, minimac3_rx_crc: byte-wide CRC-32 with init, enable and residue-ok outputs. It is instantiated only under MINIMAC3_RX_CRC_EN.

Test Plan:
- NSLOTS=2, PHY_W=4, rx_ready=2'b11, send 64-byte frame -> rxb_we[0] 64 pulses with addresses 0..63, rx_done=2'b01, rx_count slot0=64, rx_err=0.
- Two back-to-back frames (60 then 100 bytes) with both slots free -> first to slot 0, second to slot 1; counts 60/100.
- No slots free, send 3 frames -> no rxb_we, no rx_done, drop_count=3. Preload drop_count near saturation -> stays 16'hFFFF.
- SLOT_AW=6, 80-byte frame -> 63 writes, rx_count=63, rx_err=1.
- phy_rx_er pulsed at byte 10 of a 40-byte frame -> all 40 bytes written, rx_err=1. phy_rx_rst_n low at byte 20 of the next frame -> no rx_done, outputs return to 0.
- PHY_W=8 with MINIMAC3_RX_CRC_EN, valid 64-byte frame -> rx_err=0. Same frame with one bit flipped -> rx_err=1.

Source files
------------

// File: rtl/minimac3_pkg.sv
// Shared types and constants for the minimac3 receive engine.
package minimac3_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_LO   = 3'd1,
    LOAD_HI   = 3'd2,
    TERMINATE = 3'd3,
    DROP      = 3'd4
  } state_t;

  // Legal PHY data widths: MII nibbles or GMII bytes.
  localparam int unsigned PHY_W_MII  = 4;
  localparam int unsigned PHY_W_GMII = 8;

  // CRC-32 (IEEE 802.3), processed LSB first with the reflected polynomial.
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
  // Same residue as seen in a shift-right register (bit-reversed).
  localparam logic [31:0] CRC_RESIDUE_REFL = 32'hDEBB20E3;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] dat);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ dat[i]) c = (c >> 1) ^ CRC_POLY_REFL;
      else               c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/minimac3_rx_crc.sv
// Byte-wide CRC-32 checker; ok_c reports the residue including the byte presented this cycle.
module minimac3_rx_crc
  import minimac3_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic       en,
  input  logic [7:0] dat,
  output logic       ok_c
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init)    crc_d = CRC_INIT;
    else if (en) crc_d = crc32_byte(crc_q, dat);
  end

  assign ok_c = (crc_d == CRC_RESIDUE_REFL);

  always_ff @(posedge clk) begin
    if (!rst_n) crc_q <= CRC_INIT;
    else        crc_q <= crc_d;
  end

endmodule

// File: rtl/minimac3_rx.sv
// Ethernet receive engine: PHY symbols -> bytes -> host-released slot buffers.
// Define MINIMAC3_RX_CRC_EN to flag frames whose CRC-32 residue is wrong.
module minimac3_rx
  import minimac3_pkg::*;
#(
  parameter int unsigned NSLOTS  = 2,
  parameter int unsigned SLOT_AW = 11,
  parameter int unsigned PHY_W   = 4
) (
  input  logic                        phy_rx_clk,
  input  logic                        phy_rx_rst_n,
  input  logic [NSLOTS-1:0]           rx_ready,
  output logic [NSLOTS-1:0]           rx_done,
  output logic [NSLOTS-1:0]           rx_err,
  output logic [NSLOTS*SLOT_AW-1:0]   rx_count,
  output logic [7:0]                  rxb_dat,
  output logic [SLOT_AW-1:0]          rxb_adr,
  output logic [NSLOTS-1:0]           rxb_we,
  output logic [15:0]                 drop_count,
  input  logic                        phy_dv,
  input  logic [PHY_W-1:0]            phy_rx_data,
  input  logic                        phy_rx_er
);

  localparam int unsigned SLOT_IW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam bit          MII     = (PHY_W == PHY_W_MII);
  localparam logic [SLOT_AW-1:0] CNT_MAX = '1;

  state_t              state_q, state_d;
  logic [SLOT_IW-1:0]  slot_q, slot_d;
  logic [NSLOTS-1:0]   avail_q;
  logic [SLOT_AW-1:0]  cnt_d;
  logic [3:0]          lo_q, lo_d;
  logic                err_q, err_d;
  logic [7:0]          dat_d;
  logic [15:0]         drop_q, drop_d;
  logic [NSLOTS-1:0]   we_d, done_d, rerr_d;
  logic                start, cnt_upd, crc_bad_c;

  function automatic logic [SLOT_IW-1:0] lowest(input logic [NSLOTS-1:0] m);
    logic [SLOT_IW-1:0] idx;
    idx = '0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if (m[i]) idx = SLOT_IW'(i);
    end
    return idx;
  endfunction

`ifdef MINIMAC3_RX_CRC_EN
  logic crc_ok_c;

  minimac3_rx_crc u_crc (
    .clk   (phy_rx_clk),
    .rst_n (phy_rx_rst_n),
    .init  (start),
    .en    (|rxb_we),
    .dat   (rxb_dat),
    .ok_c  (crc_ok_c)
  );

  assign crc_bad_c = ~crc_ok_c;
`else
  assign crc_bad_c = 1'b0;
`endif

  assign drop_count = drop_q;

  // Next-state and next-output logic; rxb_adr doubles as the running byte count.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = rxb_adr;
    lo_d    = lo_q;
    err_d   = err_q;
    dat_d   = rxb_dat;
    drop_d  = drop_q;
    start   = 1'b0;
    cnt_upd = 1'b0;

    case (state_q)
      IDLE: begin
        slot_d = lowest(avail_q);
        if (phy_dv) begin
          if (avail_q != '0) begin
            start   = 1'b1;
            cnt_upd = 1'b1;
            cnt_d   = '0;
            err_d   = 1'b0;
            if (MII) begin
              lo_d    = 4'(phy_rx_data);
              state_d = LOAD_HI;
            end else begin
              dat_d   = 8'(phy_rx_data);
              state_d = LOAD_LO;
            end
          end else begin
            state_d = DROP;
          end
        end
      end
      LOAD_HI: begin
        if (phy_dv) begin
          dat_d   = 8'({phy_rx_data, lo_q});
          state_d = LOAD_LO;
          if (phy_rx_er) err_d = 1'b1;
        end else begin
          state_d = TERMINATE;
        end
      end
      LOAD_LO: begin
        cnt_upd = 1'b1;
        // A full slot keeps its last count; the rest of the frame is discarded.
        if (rxb_adr == CNT_MAX) err_d = 1'b1;
        else                    cnt_d = rxb_adr + SLOT_AW'(1);
        if (phy_dv) begin
          if (phy_rx_er) err_d = 1'b1;
          if (MII) begin
            lo_d    = 4'(phy_rx_data);
            state_d = LOAD_HI;
          end else begin
            dat_d   = 8'(phy_rx_data);
          end
        end else begin
          state_d = TERMINATE;
        end
      end
      TERMINATE: state_d = IDLE;
      DROP: begin
        if (!phy_dv) begin
          state_d = IDLE;
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == TERMINATE && crc_bad_c) err_d = 1'b1;

    we_d   = (state_d == LOAD_LO && cnt_d != CNT_MAX) ? (NSLOTS'(1) << slot_d) : '0;
    done_d = (state_d == TERMINATE) ? (NSLOTS'(1) << slot_d) : '0;
    rerr_d = err_d ? done_d : '0;
  end

  always_ff @(posedge phy_rx_clk) begin
    if (!phy_rx_rst_n) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      avail_q  <= '0;
      lo_q     <= '0;
      err_q    <= 1'b0;
      drop_q   <= '0;
      rx_done  <= '0;
      rx_err   <= '0;
      rx_count <= '0;
      rxb_dat  <= '0;
      rxb_adr  <= '0;
      rxb_we   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      avail_q <= (avail_q | rx_ready) & ~rx_done;
      lo_q    <= lo_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      rx_done <= done_d;
      rx_err  <= rerr_d;
      rxb_dat <= dat_d;
      rxb_adr <= cnt_d;
      rxb_we  <= we_d;
      if (cnt_upd) rx_count[int'(slot_d) * SLOT_AW +: SLOT_AW] <= cnt_d;
    end
  end

endmodule

// File: tb/tb_minimac3_rx.sv
// Directed scoreboard bench: an MII instance (2 slots, 2 KiB) and a GMII instance (2 slots, 64 B).
module tb_minimac3_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // MII instance
  logic        m_rst_n, m_dv, m_er;
  logic [3:0]  m_data;
  logic [1:0]  m_ready, m_done, m_err, m_we;
  logic [21:0] m_count;
  logic [7:0]  m_dat;
  logic [10:0] m_adr;
  logic [15:0] m_drop;

  // GMII instance
  logic        g_rst_n, g_dv, g_er;
  logic [7:0]  g_data;
  logic [1:0]  g_ready, g_done, g_err, g_we;
  logic [11:0] g_count;
  logic [7:0]  g_dat;
  logic [5:0]  g_adr;
  logic [15:0] g_drop;

  minimac3_rx #(.NSLOTS(2), .SLOT_AW(11), .PHY_W(4)) dut_m (
    .phy_rx_clk(clk), .phy_rx_rst_n(m_rst_n), .rx_ready(m_ready), .rx_done(m_done),
    .rx_err(m_err), .rx_count(m_count), .rxb_dat(m_dat), .rxb_adr(m_adr), .rxb_we(m_we),
    .drop_count(m_drop), .phy_dv(m_dv), .phy_rx_data(m_data), .phy_rx_er(m_er));

  minimac3_rx #(.NSLOTS(2), .SLOT_AW(6), .PHY_W(8)) dut_g (
    .phy_rx_clk(clk), .phy_rx_rst_n(g_rst_n), .rx_ready(g_ready), .rx_done(g_done),
    .rx_err(g_err), .rx_count(g_count), .rxb_dat(g_dat), .rxb_adr(g_adr), .rxb_we(g_we),
    .drop_count(g_drop), .phy_dv(g_dv), .phy_rx_data(g_data), .phy_rx_er(g_er));

  int vectors = 0;
  int miscompares = 0;

  // Expected writes {we, adr, dat} and completions {done, err, count}.
  logic [31:0] m_wq[$], m_dq[$], g_wq[$], g_dq[$];
  logic [7:0]  frame [0:255];

`ifdef MINIMAC3_RX_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int k = 0; k < 8; k++) begin
      fb = r[0] ^ d[k];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_done(input int slot, input bit err, input int cnt);
    logic [7:0] oh;
    oh = 8'(1 << slot);
    return {oh, err ? oh : 8'h00, 16'(cnt)};
  endfunction

  // Write and completion monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (m_we != 2'b00)
      chk("m_write", {8'(m_we), 16'(m_adr), m_dat}, (m_wq.size() != 0) ? m_wq.pop_front() : 32'hDEADBEEF);
    if (m_done != 2'b00)
      chk("m_done", {8'(m_done), 8'(m_err), 16'(m_done[1] ? m_count[21:11] : m_count[10:0])},
          (m_dq.size() != 0) ? m_dq.pop_front() : 32'hFFFFFFFF);
    else if (m_err != 2'b00)
      chk("m_err_stray", 32'(m_err), 32'h0);
    if (g_we != 2'b00)
      chk("g_write", {8'(g_we), 16'(g_adr), g_dat}, (g_wq.size() != 0) ? g_wq.pop_front() : 32'hDEADBEEF);
    if (g_done != 2'b00)
      chk("g_done", {8'(g_done), 8'(g_err), 16'(g_done[1] ? g_count[11:6] : g_count[5:0])},
          (g_dq.size() != 0) ? g_dq.pop_front() : 32'hFFFFFFFF);
    else if (g_err != 2'b00)
      chk("g_err_stray", 32'(g_err), 32'h0);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_release(input logic [1:0] mask);
    @(negedge clk); m_ready = mask;
    @(negedge clk); m_ready = 2'b00;
  endtask

  task automatic g_release(input logic [1:0] mask);
    @(negedge clk); g_ready = mask;
    @(negedge clk); g_ready = 2'b00;
  endtask

  task automatic fill(input int len);
    for (int i = 0; i < len; i++) frame[i] = 8'($urandom);
  endtask

  // MII frame, low nibble first; slot < 0 means no writes expected. Stops early at abort_at.
  task automatic send_m(input int len, input int er_at, input int slot, input int abort_at);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) return;
      b = frame[i];
      @(negedge clk); m_dv = 1'b1; m_data = b[3:0]; m_er = (i == er_at);
      @(negedge clk); m_data = b[7:4]; m_er = 1'b0;
      if (slot >= 0) m_wq.push_back({8'(1 << slot), 16'(i), b});
    end
    @(negedge clk); m_dv = 1'b0; m_data = 4'h0; m_er = 1'b0;
  endtask

  // GMII frame into a 64-byte slot: only the first 63 bytes can land.
  task automatic send_g(input int len, input int slot);
    for (int i = 0; i < len; i++) begin
      @(negedge clk); g_dv = 1'b1; g_data = frame[i];
      if (slot >= 0 && i < 63) g_wq.push_back({8'(1 << slot), 16'(i), frame[i]});
    end
    @(negedge clk); g_dv = 1'b0; g_data = 8'h00;
  endtask

  initial begin
    logic [31:0] crc;
    m_rst_n = 1'b0; m_dv = 1'b0; m_er = 1'b0; m_data = '0; m_ready = '0;
    g_rst_n = 1'b0; g_dv = 1'b0; g_er = 1'b0; g_data = '0; g_ready = '0;
    idle(3);
    chk("m_reset_outs", {8'(m_done), 8'(m_err), 8'(m_we), m_dat}, 32'h0);
    chk("m_reset_cnt",  {m_drop, 5'(0), m_adr}, 32'h0);
    chk("m_reset_rxc",  32'(m_count), 32'h0);
    chk("g_reset_outs", {8'(g_done), 8'(g_err), 8'(g_we), g_dat}, 32'h0);
    m_rst_n = 1'b1; g_rst_n = 1'b1;
    idle(2);

    // 64-byte MII frame into slot 0
    m_release(2'b11);
    fill(64);
    send_m(64, -1, 0, -1);
    m_dq.push_back(exp_done(0, 1'b0, 64));
    idle(8);
    chk("m_count_slot0_64", 32'(m_count[10:0]), 32'd64);

    // back-to-back 60 then 100 bytes: slot 0 then slot 1
    m_release(2'b01);
    fill(60);
    send_m(60, -1, 0, -1);
    m_dq.push_back(exp_done(0, 1'b0, 60));
    idle(8);
    fill(100);
    send_m(100, -1, 1, -1);
    m_dq.push_back(exp_done(1, 1'b0, 100));
    idle(8);
    chk("m_counts_60_100", {5'(0), m_count[21:11], 5'(0), m_count[10:0]}, {16'd100, 16'd60});

    // no free slot: three drops
    for (int f = 0; f < 3; f++) begin
      fill(8);
      send_m(8, -1, -1, -1);
      idle(4);
    end
    chk("m_drop_3", 32'(m_drop), 32'd3);

    // saturation from near the top
    @(negedge clk);
    force dut_m.drop_q = 16'hFFFD;
    @(negedge clk);
    release dut_m.drop_q;
    for (int f = 0; f < 3; f++) begin
      fill(4);
      send_m(4, -1, -1, -1);
      idle(4);
    end
    chk("m_drop_sat", 32'(m_drop), 32'h0000FFFF);

    // PHY error at byte 10 of a 40-byte frame; every byte still written
    m_release(2'b01);
    fill(40);
    send_m(40, 10, 0, -1);
    m_dq.push_back(exp_done(0, 1'b1, 40));
    idle(8);

    // error flag cleared by the next frame start
    m_release(2'b01);
    fill(20);
    send_m(20, -1, 0, -1);
    m_dq.push_back(exp_done(0, 1'b0, 20));
    idle(8);

    // reset at byte 20 abandons the frame with no completion
    m_release(2'b01);
    fill(50);
    send_m(50, -1, 0, 20);
    @(negedge clk); m_rst_n = 1'b0; m_dv = 1'b0; m_data = 4'h0;
    idle(2);
    chk("m_abort_outs", {8'(m_done), 8'(m_err), 8'(m_we), m_dat}, 32'h0);
    chk("m_abort_cnt",  {m_drop, 5'(0), m_adr}, 32'h0);
    chk("m_abort_rxc",  32'(m_count), 32'h0);
    m_rst_n = 1'b1;
    idle(2);
    // reset also withdrew every released slot
    fill(6);
    send_m(6, -1, -1, -1);
    idle(4);
    chk("m_drop_after_rst", 32'(m_drop), 32'd1);

    // GMII: valid 32-byte frame (28 data + FCS) into slot 0
    g_release(2'b11);
    fill(28);
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < 28; i++) crc = crc_upd(crc, frame[i]);
    crc = ~crc;
    for (int k = 0; k < 4; k++) frame[28 + k] = crc[8 * k +: 8];
    send_g(32, 0);
    g_dq.push_back(exp_done(0, 1'b0, 32));
    idle(6);

    // same frame with one bit flipped into slot 1
    frame[5] = frame[5] ^ 8'h10;
    send_g(32, 1);
    g_dq.push_back(exp_done(1, CRC_ON, 32));
    idle(6);

    // 80 bytes into a 64-byte slot: 63 written, truncation flagged
    g_release(2'b01);
    fill(80);
    send_g(80, 0);
    g_dq.push_back(exp_done(0, 1'b1, 63));
    idle(6);
    chk("g_trunc_count", 32'(g_count[5:0]), 32'd63);
    chk("g_drop_zero", 32'(g_drop), 32'd0);

    idle(4);
    chk("m_writes_left", 32'(m_wq.size()), 32'd0);
    chk("m_dones_left",  32'(m_dq.size()), 32'd0);
    chk("g_writes_left", 32'(g_wq.size()), 32'd0);
    chk("g_dones_left",  32'(g_dq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
